// File: rtl/seven_seg_pkg.sv
// Shared constants and scan-state encoding for the multiplexed seven-segment scanner.
package seven_seg_pkg;

    localparam int NDIG_DEF  = 4;
    localparam int DW_DEF    = 4;
    localparam int PRESC_DEF = 50000;
    localparam int BLANK_DEF = 16;

    // Wide enough for any practical digit count; users slice off NDIG bits.
    localparam int                 MAX_DIG   = 32;
    localparam logic [MAX_DIG-1:0] ANODE_OFF = '1;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Application-side load/ack handshake of the scanner.
interface seven_seg_scanner_if
    import seven_seg_pkg::*;
#(
    parameter int NDIG = NDIG_DEF,
    parameter int DW   = DW_DEF
);

    logic               load;
    logic [NDIG*DW-1:0] din;
    logic [NDIG-1:0]    dot_in;
    logic               lz_en;
    logic               upd_ack;
    logic               frame_tick;

    modport master (
        output load, din, dot_in, lz_en,
        input  upd_ack, frame_tick
    );

    modport slave (
        input  load, din, dot_in, lz_en,
        output upd_ack, frame_tick
    );

endinterface

// File: rtl/seven_seg_scanner_scan_timer.sv
// Slot/digit sequencer: cnt runs 0..PRESC-1 per slot, idx steps through the digits,
// and the scan state is BLANK for the first BLANK cycles of each slot.
module scan_timer
    import seven_seg_pkg::*;
#(
    parameter int PRESC = PRESC_DEF,
    parameter int BLANK = BLANK_DEF,
    parameter int NDIG  = NDIG_DEF,
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            show,
    output logic [IDXW-1:0] idx,
    output logic            boundary
);

    localparam int             CNTW       = $clog2(PRESC);
    localparam logic [CNTW-1:0] CNT_LAST   = CNTW'(PRESC - 1);
    localparam logic [CNTW-1:0] BLANK_LAST = CNTW'(BLANK - 1);
    localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(NDIG - 1);

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [0:0]      state_q, state_d;

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        state_d = state_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_BLANK;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= ST_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

    assign show     = (state_q == ST_SHOW);
    assign idx      = idx_q;
    assign boundary = (cnt_q == '0) && (idx_q == '0);

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode display scanner with frame-aligned updates and
// leading-zero suppression; drives an external hex decoder through dig_val/dig_dot.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NDIG  = NDIG_DEF,
    parameter int DW    = DW_DEF,
    parameter int PRESC = PRESC_DEF,
    parameter int BLANK = BLANK_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    seven_seg_scanner_if.slave  bus,
    output logic [DW-1:0]       dig_val,
    output logic                dig_dot,
    output logic [NDIG-1:0]     an
);

    localparam int              IDXW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [NDIG-1:0] AN_OFF = ANODE_OFF[NDIG-1:0];

    logic            show;
    logic [IDXW-1:0] idx;
    logic            boundary;

    scan_timer #(
        .PRESC (PRESC),
        .BLANK (BLANK),
        .NDIG  (NDIG)
    ) u_scan_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .show     (show),
        .idx      (idx),
        .boundary (boundary)
    );

    logic [NDIG*DW-1:0] act_val_q,  act_val_d;
    logic [NDIG-1:0]    act_dot_q,  act_dot_d;
    logic [NDIG*DW-1:0] pend_val_q, pend_val_d;
    logic [NDIG-1:0]    pend_dot_q, pend_dot_d;
    logic               pend_v_q,   pend_v_d;
    logic               upd_ack_q,  upd_ack_d;
    logic               frame_tick_q, frame_tick_d;
    logic [DW-1:0]      dig_val_q,  dig_val_d;
    logic               dig_dot_q,  dig_dot_d;
    logic [NDIG-1:0]    an_q,       an_d;
    logic [NDIG-1:0]    lz_blank;
    logic               zero_above;

    // Handshake: loads park in pending and are promoted only at the frame boundary;
    // a load coinciding with the boundary goes straight to active.
    always_comb begin
        act_val_d    = act_val_q;
        act_dot_d    = act_dot_q;
        pend_val_d   = pend_val_q;
        pend_dot_d   = pend_dot_q;
        pend_v_d     = pend_v_q;
        upd_ack_d    = 1'b0;
        frame_tick_d = boundary;
        if (boundary) begin
            if (bus.load) begin
                act_val_d = bus.din;
                act_dot_d = bus.dot_in;
                pend_v_d  = 1'b0;
                upd_ack_d = 1'b1;
            end else if (pend_v_q) begin
                act_val_d = pend_val_q;
                act_dot_d = pend_dot_q;
                pend_v_d  = 1'b0;
                upd_ack_d = 1'b1;
            end
        end else if (bus.load) begin
            pend_val_d = bus.din;
            pend_dot_d = bus.dot_in;
            pend_v_d   = 1'b1;
        end
    end

    // Outputs look at the next active value so the first cycle of a new frame
    // already shows the freshly promoted data.
    always_comb begin
        // NOTE: combinational blocks use blocking assignments and give every
        // target a default first, so no latch is inferred and the running
        // zero_above chain reads its own updated value.
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            zero_above  = zero_above && (act_val_d[k*DW +: DW] == '0);
            lz_blank[k] = bus.lz_en && zero_above && (k != 0);
        end

        dig_val_d = act_val_d[int'(idx)*DW +: DW];
        dig_dot_d = act_dot_d[idx];
        an_d      = AN_OFF;
        if (show && !lz_blank[idx]) begin
            an_d[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_val_q    <= '0;
            act_dot_q    <= '0;
            pend_val_q   <= '0;
            pend_dot_q   <= '0;
            pend_v_q     <= 1'b0;
            upd_ack_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            dig_val_q    <= '0;
            dig_dot_q    <= 1'b0;
            an_q         <= AN_OFF;
        end else begin
            act_val_q    <= act_val_d;
            act_dot_q    <= act_dot_d;
            pend_val_q   <= pend_val_d;
            pend_dot_q   <= pend_dot_d;
            pend_v_q     <= pend_v_d;
            upd_ack_q    <= upd_ack_d;
            frame_tick_q <= frame_tick_d;
            dig_val_q    <= dig_val_d;
            dig_dot_q    <= dig_dot_d;
            an_q         <= an_d;
        end
    end

    assign dig_val        = dig_val_q;
    assign dig_dot        = dig_dot_q;
    assign an             = an_q;
    assign bus.upd_ack    = upd_ack_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with NDIG=4, PRESC=8, BLANK=2; every output
// is compared cycle by cycle against hand-derived slot patterns.
module tb_seven_seg_scanner;

    localparam int NDIG  = 4;
    localparam int DW    = 4;
    localparam int PRESC = 8;
    localparam int BLANK = 2;
    localparam int FRAME = NDIG * PRESC;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   dig_val;
    logic            dig_dot;
    logic [NDIG-1:0] an;

    int checks   = 0;
    int failures = 0;

    seven_seg_scanner_if #(.NDIG(NDIG), .DW(DW)) bus ();

    seven_seg_scanner #(
        .NDIG  (NDIG),
        .DW    (DW),
        .PRESC (PRESC),
        .BLANK (BLANK)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .dig_val (dig_val),
        .dig_dot (dig_dot),
        .an      (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called on the negedge of the frame_tick cycle. Cycle j of the frame shows
    // slot j/8, position j%8: anodes dark for positions 0..1, lit for 2..7.
    task automatic run_frame(
        input string       tag,
        input logic [15:0] val,
        input logic [3:0]  dot,
        input logic        ack,
        input logic        lz,
        input int          la_j,
        input logic [15:0] la_val,
        input logic [3:0]  la_dot,
        input int          lb_j,
        input logic [15:0] lb_val,
        input logic [3:0]  lb_dot
    );
        int         s;
        int         c;
        logic       sup;
        logic [3:0] exp_an;
        bus.lz_en = lz;
        for (int j = 0; j < FRAME; j++) begin
            s      = j / PRESC;
            c      = j % PRESC;
            sup    = lz && (s > 0) && ((val >> (4 * s)) == 16'h0);
            exp_an = 4'hF;
            if (c >= BLANK && !sup) exp_an[s] = 1'b0;
            check($sformatf("%s an j=%0d", tag, j), 32'(an), 32'(exp_an));
            check($sformatf("%s dig_val j=%0d", tag, j), 32'(dig_val), 32'(val[4*s +: 4]));
            check($sformatf("%s dig_dot j=%0d", tag, j), 32'(dig_dot), 32'(dot[s]));
            check($sformatf("%s frame_tick j=%0d", tag, j), 32'(bus.frame_tick), 32'(j == 0));
            check($sformatf("%s upd_ack j=%0d", tag, j), 32'(bus.upd_ack), 32'((j == 0) && ack));
            if (j == la_j) begin
                bus.load   = 1'b1;
                bus.din    = la_val;
                bus.dot_in = la_dot;
            end else if (j == lb_j) begin
                bus.load   = 1'b1;
                bus.din    = lb_val;
                bus.dot_in = lb_dot;
            end else begin
                bus.load = 1'b0;
            end
            @(negedge clk);
        end
        bus.load = 1'b0;
    endtask

    initial begin
        bus.load   = 1'b0;
        bus.din    = '0;
        bus.dot_in = '0;
        bus.lz_en  = 1'b0;
        rst_n      = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst an", 32'(an), 32'hF);
        check("rst dig_val", 32'(dig_val), 32'h0);
        check("rst dig_dot", 32'(dig_dot), 32'h0);
        check("rst frame_tick", 32'(bus.frame_tick), 32'h0);
        check("rst upd_ack", 32'(bus.upd_ack), 32'h0);

        // First frame after release; load 1234 mid-frame stays pending
        rst_n = 1'b1;
        @(negedge clk);
        run_frame("f0", 16'h0000, 4'b0000, 1'b0, 1'b0, 12, 16'h1234, 4'b0100, -1, 16'h0, 4'h0);

        // 1234 now active; two loads, last one wins
        run_frame("f1", 16'h1234, 4'b0100, 1'b1, 1'b0, 5, 16'hAAAA, 4'h0, 20, 16'h00F0, 4'h0);

        // 00F0 active; load on the boundary edge itself
        run_frame("f2", 16'h00F0, 4'b0000, 1'b1, 1'b0, 31, 16'h0050, 4'b1000, -1, 16'h0, 4'h0);
        run_frame("f3", 16'h0050, 4'b1000, 1'b1, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        // Leading-zero suppression; the dot on digit 3 does not keep it lit
        run_frame("f4", 16'h0050, 4'b1000, 1'b0, 1'b1, 31, 16'h0000, 4'h0, -1, 16'h0, 4'h0);
        run_frame("f5", 16'h0000, 4'b0000, 1'b1, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        // Reset during slot 2 with a pending load
        bus.lz_en = 1'b0;
        check("f6 frame_tick", 32'(bus.frame_tick), 32'h1);
        for (int j = 0; j < 20; j++) begin
            if (j == 17) begin
                bus.load   = 1'b1;
                bus.din    = 16'h9876;
                bus.dot_in = 4'hF;
            end else begin
                bus.load = 1'b0;
            end
            @(negedge clk);
        end
        check("f6 an slot2", 32'(an), 32'hB);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid rst an", 32'(an), 32'hF);
        check("mid rst dig_val", 32'(dig_val), 32'h0);
        check("mid rst dig_dot", 32'(dig_dot), 32'h0);
        check("mid rst upd_ack", 32'(bus.upd_ack), 32'h0);
        check("mid rst frame_tick", 32'(bus.frame_tick), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame("post", 16'h0000, 4'b0000, 1'b0, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        check("post2 frame_tick", 32'(bus.frame_tick), 32'h1);
        check("post2 upd_ack", 32'(bus.upd_ack), 32'h0);
        check("post2 dig_val", 32'(dig_val), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
